// File: rtl/if_fetch_icache.sv
// if_fetch_icache
//   Instruction-fetch stage: program counter, next-PC select, a direct-mapped
//   instruction cache and the IF/ID pipeline register. A missing line is
//   refilled from memory one beat per ack, at ascending addresses from the
//   line base.
//
//   Optional feature macro: ICACHE_PERF_EN enables the saturating hit/miss
//   performance counters. When it is undefined the counter outputs are tied to 0.
//
// Ports
//   Clk, Rst                  clock (posedge), asynchronous active-low reset
//   PC_Write                  PC update enable
//   IF_Write, IF_Flush        IF/ID load enable / clear to NOP
//   addrSel                   00 PC+4, 01 jumpTarget, 10 branchTarget, 11 EXC_VECTOR
//   jumpTarget, branchTarget  redirect targets
//   CacheMiss                 fetch word at PC not available this cycle (combinational)
//   PC                        current fetch PC
//   IF_ID_Instr, IF_ID_PCPlus4  IF/ID register contents
//   memReq, memAddr           refill request and current beat byte address
//   memAck, memData           beat accepted, refill word (same cycle)
//   hitCount, missCount       performance counters
//
// FSM states
//   IDLE | cache lookup; a miss latches the line base and starts the refill
//   FILL | one word written per memAck; the last ack ends the burst
//   DONE | tag written and line marked valid
module if_fetch_icache #(
    parameter int unsigned LINES      = 16,
    parameter int unsigned WORDS      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        PC_Write,
    input  logic        IF_Write,
    input  logic        IF_Flush,
    input  logic [1:0]  addrSel,
    input  logic [31:0] jumpTarget,
    input  logic [31:0] branchTarget,
    output logic        CacheMiss,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData,
    output logic [31:0] hitCount,
    output logic [31:0] missCount
);

    localparam int unsigned OFF_W   = $clog2(WORDS);
    localparam int unsigned IDX_W   = $clog2(LINES);
    localparam int unsigned IDX_LSB = OFF_W + 2;
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
    localparam int unsigned TAG_W   = 32 - TAG_LSB;
    localparam logic [OFF_W-1:0] BEAT_LAST = OFF_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t            state;
    logic [OFF_W-1:0]  beat;
    logic [31:0]       line_base;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_ram  [LINES];
    logic [31:0]       data_ram [LINES][WORDS];

    logic [OFF_W-1:0]  pc_off;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              hit;
    logic [31:0]       pc_plus4;
    logic [31:0]       fetch_word;

    assign pc_off     = PC[IDX_LSB-1:2];
    assign pc_idx     = PC[TAG_LSB-1:IDX_LSB];
    assign pc_tag     = PC[31:TAG_LSB];
    // The refill target comes from the latched line base so a redirect
    // during the burst cannot retarget a half-written line.
    assign fill_idx   = line_base[TAG_LSB-1:IDX_LSB];
    assign fill_tag   = line_base[31:TAG_LSB];

    assign hit        = (state == IDLE) && valid[pc_idx] && (tag_ram[pc_idx] == pc_tag);
    assign CacheMiss  = !hit;
    assign pc_plus4   = PC + 32'd4;
    assign fetch_word = data_ram[pc_idx][pc_off];
    // beat returns to 0 at the end of a burst, so this is 0 out of reset.
    assign memAddr    = line_base + {{(30 - OFF_W){1'b0}}, beat, 2'b00};

    // Refill controller and valid bits
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            beat      <= '0;
            line_base <= '0;
            memReq    <= 1'b0;
            valid     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        line_base <= {PC[31:IDX_LSB], {IDX_LSB{1'b0}}};
                        beat      <= '0;
                        memReq    <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (memAck) begin
                        if (beat == BEAT_LAST) begin
                            beat   <= '0;
                            memReq <= 1'b0;
                            state  <= DONE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                DONE: begin
                    valid[fill_idx] <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge Clk) begin
        if (state == FILL && memAck) begin
            data_ram[fill_idx][beat] <= memData;
        end
        if (state == DONE) begin
            tag_ram[fill_idx] <= fill_tag;
        end
    end

    // PC and IF/ID register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            PC            <= RESET_PC;
            IF_ID_Instr   <= '0;
            IF_ID_PCPlus4 <= '0;
        end else begin
            if (PC_Write) begin
                case (addrSel)
                    2'b00:   if (!CacheMiss) PC <= pc_plus4;
                    2'b01:   PC <= jumpTarget;
                    2'b10:   PC <= branchTarget;
                    default: PC <= EXC_VECTOR;
                endcase
            end
            if (IF_Flush || (IF_Write && CacheMiss)) begin
                IF_ID_Instr   <= '0;
                IF_ID_PCPlus4 <= '0;
            end else if (IF_Write) begin
                IF_ID_Instr   <= fetch_word;
                IF_ID_PCPlus4 <= pc_plus4;
            end
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit && IF_Write && hit_cnt != 32'hFFFF_FFFF) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (state == IDLE && !hit && miss_cnt != 32'hFFFF_FFFF) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign hitCount  = hit_cnt;
    assign missCount = miss_cnt;
`else
    assign hitCount  = '0;
    assign missCount = '0;
`endif

endmodule
